// File: rtl/imm_packer_if.sv
// Handshake and data bundle for the imm_packer instruction-bit packer.
interface imm_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  CEU;
  logic [31:0] imm;
  logic [24:0] fields;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] Dint;
  logic        err;
  logic [7:0]  err_cnt;

  modport master (
    output in_valid, CEU, imm, fields, out_ready,
    input  in_ready, out_valid, Dint, err, err_cnt
  );

  modport slave (
    input  in_valid, CEU, imm, fields, out_ready,
    output in_ready, out_valid, Dint, err, err_cnt
  );
endinterface

// File: rtl/imm_packer.sv
// Two-stage immediate packer: scatters an immediate into instruction bits [31:7].
// Define IMMPACK_CHECK_EN to enable representability checking and err/err_cnt.
module imm_packer (
  input logic         clk,
  input logic         rst_n,
  imm_packer_if.slave bus
);
  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  logic        vld_p1, vld_p2;
  logic [2:0]  ceu_p1;
  logic [31:0] imm_p1;
  logic [24:0] fields_p1;
  logic        bad_p1;
  logic        bad_in;
  logic [24:0] dint_p2;
  logic        err_p2;
  logic [7:0]  err_cnt_q;
  logic        adv_p1, adv_p2, in_hs, out_hs;

  function automatic logic [24:0] pack_imm(input logic [2:0] ceu, input logic [31:0] imm,
                                           input logic [24:0] fields);
    logic [24:0] d;
    d = fields;
    case (ceu)
      FMT_I: d[24:13] = imm[11:0];
      FMT_S: begin
        d[24:18] = imm[11:5];
        d[4:0]   = imm[4:0];
      end
      FMT_B: begin
        d[24]    = imm[12];
        d[23:18] = imm[10:5];
        d[4:1]   = imm[4:1];
        d[0]     = imm[11];
      end
      FMT_U: d[24:5] = imm[31:12];
      FMT_J: begin
        d[24]    = imm[20];
        d[23:14] = imm[10:1];
        d[13]    = imm[11];
        d[12:5]  = imm[19:12];
      end
      default: d = fields;
    endcase
    return d;
  endfunction

`ifdef IMMPACK_CHECK_EN
  // Upper bits must be a pure sign extension of the encodable field.
  function automatic logic imm_bad(input logic [2:0] ceu, input logic [31:0] imm);
    logic bad;
    case (ceu)
      FMT_I, FMT_S: bad = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_U:        bad = |imm[11:0];
      FMT_J:        bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign bad_in = imm_bad(bus.CEU, bus.imm);
`else
  assign bad_in = 1'b0;
`endif

  assign adv_p2       = !vld_p2 || bus.out_ready;
  assign adv_p1       = !vld_p1 || adv_p2;
  assign in_hs        = bus.in_valid && adv_p1;
  assign out_hs       = vld_p2 && bus.out_ready;
  assign bus.in_ready = adv_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      if (adv_p1) vld_p1 <= bus.in_valid;
      if (adv_p2) vld_p2 <= vld_p1;
      if (out_hs && err_p2 && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // stage 1: capture operands and the range-check result
  always_ff @(posedge clk) begin
    if (in_hs) begin
      ceu_p1    <= bus.CEU;
      imm_p1    <= bus.imm;
      fields_p1 <= bus.fields;
      bad_p1    <= bad_in;
    end
  end

  // stage 2: packed word, cleared on reset so the idle output reads zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dint_p2 <= 25'd0;
      err_p2  <= 1'b0;
    end else if (vld_p1 && adv_p2) begin
      dint_p2 <= pack_imm(ceu_p1, imm_p1, fields_p1);
      err_p2  <= bad_p1;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.Dint      = dint_p2;
  assign bus.err       = err_p2;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_imm_packer.sv
// Directed bench for imm_packer: packing vectors, latency, stall, reset and saturation.
module tb_imm_packer;
`ifdef IMMPACK_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  imm_packer_if bus ();

  imm_packer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int sent, rcvd, nhs;
  logic saw_full;
  logic [24:0] bp_exp [5] = '{25'h20, 25'h40, 25'h60, 25'h80, 25'hA0};
  logic [24:0] d;
  logic        e;
  logic [31:0] r, r2, im;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // EXT: sign-extending immediate decoder, used to close the round trip
  function automatic logic [31:0] ext(input logic [2:0] c, input logic [24:0] x);
    case (c)
      3'd0:    return {{20{x[24]}}, x[24:13]};
      3'd1:    return {{20{x[24]}}, x[24:18], x[4:0]};
      3'd2:    return {{19{x[24]}}, x[24], x[0], x[23:18], x[4:1], 1'b0};
      3'd3:    return {x[24:5], 12'h000};
      3'd4:    return {{11{x[24]}}, x[24], x[12:5], x[13], x[23:14], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic run_xact(input logic [2:0] c, input logic [31:0] iv, input logic [24:0] f,
                          output logic [24:0] dout, output logic eout);
    @(negedge clk);
    bus.CEU = c; bus.imm = iv; bus.fields = f;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1 chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("lat1_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat2_out_valid", 32'(bus.out_valid), 32'd1);
    dout = bus.Dint;
    eout = bus.err;
  endtask

  task automatic dv(input string tag, input logic [2:0] c, input logic [31:0] iv,
                    input logic [24:0] f, input logic [24:0] ed, input logic ee);
    logic [24:0] dd;
    logic        ea;
    run_xact(c, iv, f, dd, ea);
    chk({tag, "_dint"}, 32'(dd), 32'(ed));
    chk({tag, "_err"}, 32'(ea), 32'(ee));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.CEU = 3'd0; bus.imm = 32'd0; bus.fields = 25'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_dint", 32'(bus.Dint), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    dv("i_neg1",   3'd0, 32'hFFFFFFFF, 25'h0000000, 25'h1FFE000, 1'b0);
    dv("u_ok",     3'd3, 32'h12345000, 25'h000001F, 25'h02468BF, 1'b0);
    @(negedge clk);
    chk("err_cnt_0", 32'(bus.err_cnt), 32'd0);
    dv("u_bad",    3'd3, 32'h12345001, 25'h000001F, 25'h02468BF, CHK);
    @(negedge clk);
    chk("err_cnt_1", 32'(bus.err_cnt), 32'(CHK));
    dv("b_ffe",    3'd2, 32'h00000FFE, 25'h0000000, 25'h0FC001F, 1'b0);
    dv("b_odd",    3'd2, 32'h00000001, 25'h0000000, 25'h0000000, CHK);
    dv("j_3",      3'd4, 32'h00000003, 25'h0000000, 25'h0004000, CHK);
    dv("s_7ff",    3'd1, 32'h000007FF, 25'h1FFFFFF, 25'h0FFFFFF, 1'b0);
    dv("s_min",    3'd1, 32'hFFFFF800, 25'h0000000, 25'h1000000, 1'b0);
    dv("i_fields", 3'd0, 32'h00000000, 25'h1FFFFFF, 25'h0001FFF, 1'b0);
    dv("j_min",    3'd4, 32'hFFF00000, 25'h0000000, 25'h1000000, 1'b0);
    dv("i_2048",   3'd0, 32'h00000800, 25'h0000000, 25'h1000000, CHK);
    dv("rsv_5",    3'd5, 32'h12345678, 25'h0ABCDEF, 25'h0ABCDEF, CHK);
    dv("rsv_7",    3'd7, 32'h00000000, 25'h1555555, 25'h1555555, CHK);

    // back-pressure: out_ready low for cycles 3..6 of a 5-entry stream
    sent = 0; rcvd = 0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 40 && rcvd < 5; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 3 && cyc < 7);
      bus.in_valid  = (sent < 5);
      bus.CEU = 3'd3; bus.imm = 32'(sent + 1) << 12; bus.fields = 25'd0;
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'(((sent - rcvd) < 2) || bus.out_ready));
      if (!bus.in_ready) saw_full = 1'b1;
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_dint", 32'(bus.Dint), 32'(bp_exp[rcvd]));
        rcvd++;
      end
    end
    bus.in_valid = 1'b0;
    chk("bp_count", 32'(rcvd), 32'd5);
    chk("bp_stalled", 32'(saw_full), 32'd1);

    // reset with two entries held in the pipeline
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.CEU = 3'd0; bus.imm = 32'd5; bus.fields = 25'd0;
    @(negedge clk);
    bus.imm = 32'd6;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1; bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // round trip through EXT with in-range random immediates
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 8; k++) begin
        r = $urandom; r2 = $urandom;
        case (c)
          0, 1:    im = {{20{r[11]}}, r[11:0]};
          2:       im = {{19{r[12]}}, r[12:1], 1'b0};
          3:       im = {r[31:12], 12'h000};
          default: im = {{11{r[20]}}, r[20:1], 1'b0};
        endcase
        run_xact(3'(c), im, r2[24:0], d, e);
        chk("rt_ext", ext(3'(c), d), im);
        chk("rt_err", 32'(e), 32'd0);
      end
    end

    // 300 unrepresentable U immediates: counter must saturate, not wrap
    @(negedge clk);
    bus.CEU = 3'd3; bus.imm = 32'd1; bus.fields = 25'd0; bus.out_ready = 1'b1;
    nhs = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      bus.in_valid = (nhs < 300);
      #1;
      if (bus.in_valid && bus.in_ready) nhs++;
    end
    chk("sat_handshakes", 32'(nhs), 32'd300);
    chk("sat_err_cnt", 32'(bus.err_cnt), CHK ? 32'd255 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
